// File: rtl/inv_shift_rows_stage_if.sv
// Block-level bundle for the InvShiftRows stage: upstream block input,
// downstream block output and the delivered-block counter.
interface inv_shift_rows_stage_if #(
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        line0;
    logic [31:0]        line1;
    logic [31:0]        line2;
    logic [31:0]        line3;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        outline0;
    logic [31:0]        outline1;
    logic [31:0]        outline2;
    logic [31:0]        outline3;
    logic [COUNT_W-1:0] blk_count;

    // Environment side: produces blocks upstream and consumes them downstream.
    modport master (
        output in_valid, line0, line1, line2, line3, out_ready,
        input  in_ready, out_valid, outline0, outline1, outline2, outline3, blk_count
    );

    // Stage side.
    modport slave (
        input  in_valid, line0, line1, line2, line3, out_ready,
        output in_ready, out_valid, outline0, outline1, outline2, outline3, blk_count
    );
endinterface

// File: rtl/inv_shift_rows_stage.sv
// AES InvShiftRows pipeline stage: transforms on write into a 2-entry FIFO,
// presents the head entry downstream and counts delivered blocks.
module inv_shift_rows_stage #(
    parameter int COUNT_W = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    inv_shift_rows_stage_if.slave bus
);
    // Handshake: a block moves on a rising edge where valid and ready are both 1.
    // in_ready depends only on registered occupancy, never on out_ready, and
    // out_valid/outline* come straight from registers (no input-to-output path).

    logic [127:0]       xf;
    logic [127:0]       head_q, head_d;
    logic [127:0]       tail_q, tail_d;
    logic [1:0]         occ_q, occ_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [COUNT_W-1:0] blk_count_q;
    logic               push;
    logic               pop;

    assign xf = {bus.line0,
                 bus.line1[7:0],  bus.line1[31:8],
                 bus.line2[15:0], bus.line2[31:16],
                 bus.line3[23:0], bus.line3[31:24]};

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = xf;
                else               tail_d = xf;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                // Head keeps its value when draining to empty so outputs hold.
                if (occ_q == 2'd2) head_d = tail_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at occupancy 1: the new block replaces the head.
                head_d = xf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            blk_count_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            in_ready_q  <= (occ_d != 2'd2);
            out_valid_q <= (occ_d != 2'd0);
            if (pop) blk_count_q <= blk_count_q + COUNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.outline0  = head_q[127:96];
    assign bus.outline1  = head_q[95:64];
    assign bus.outline2  = head_q[63:32];
    assign bus.outline3  = head_q[31:0];
    assign bus.blk_count = blk_count_q;
endmodule
